scaler_line_ring: RTL

Multi-line ring buffer between the video input and the vertical/horizontal scaler.
- Stores up to LINES lines of YCbCr422 pixels.
- Returns two vertically adjacent lines at the same x as YCbCr444 in one read, for bilinear vertical interpolation.
- Tracks line occupancy with backpressure on the write side and explicit line release on the read side.
- Single clock domain; sits after the input CSC/crop stage and before the scaler kernel.

---
 rtl/scaler_line_ring.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/scaler_line_ring.sv
// Multi-line YCbCr422 ring buffer feeding the scaler; returns two adjacent lines as 444.
// Optional macro SCALER_LB_CLAMP_EN: per-slot line length with rd_x clamping (+1 read latency).
module scaler_line_ring #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_WIDTH = 1920,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned LINES     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sof,
    input  logic                         wr_valid,
    input  logic [2*DATA_W-1:0]          wr_data,
    input  logic                         wr_eol,
    output logic                         wr_ready,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_x,
    input  logic                         rd_release,
    output logic                         rd_valid,
    output logic [3*DATA_W-1:0]          rd_q0,
    output logic [3*DATA_W-1:0]          rd_q1,
    output logic [$clog2(LINES+1)-1:0]   lines_avail,
    output logic                         wr_overflow
);
    localparam int unsigned SLOT_W = $clog2(LINES);
    localparam int unsigned CNT_W  = $clog2(LINES+1);
    localparam int unsigned YDEPTH = LINES << ADDR_W;
    localparam int unsigned CDEPTH = LINES << (ADDR_W-1);

    logic [DATA_W-1:0] r_y_ram  [YDEPTH];
    logic [DATA_W-1:0] r_cb_ram [CDEPTH];
    logic [DATA_W-1:0] r_cr_ram [CDEPTH];

    // One extra bit so wr_x can sit at MAX_WIDTH even when MAX_WIDTH == 2**ADDR_W.
    logic [ADDR_W:0]    r_wr_x;
    logic [SLOT_W-1:0]  r_wr_slot, r_rd_slot;
    logic [CNT_W-1:0]   r_lines, w_lines_nxt;
    logic               r_wr_ready, r_overflow;

    logic               w_wr_acc, w_wr_drop, w_wr_mem, w_commit, w_release, w_rd_acc;
    logic [ADDR_W-1:0]  w_wr_addr;

    assign w_wr_acc  = wr_valid & r_wr_ready & ~sof & ~rst;
    assign w_wr_drop = (r_wr_x == (ADDR_W+1)'(MAX_WIDTH));
    assign w_wr_mem  = w_wr_acc & ~w_wr_drop;
    assign w_commit  = w_wr_acc & wr_eol;
    assign w_release = rd_release & (r_lines != '0) & ~sof & ~rst;
    assign w_rd_acc  = rd_en & (r_lines >= CNT_W'(2)) & ~sof & ~rst;
    assign w_wr_addr = r_wr_x[ADDR_W-1:0];

    always_comb begin
        w_lines_nxt = r_lines;
        if (w_commit && !w_release) begin
            w_lines_nxt = r_lines + 1'b1;
        end else if (!w_commit && w_release) begin
            w_lines_nxt = r_lines - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sof) begin
            r_wr_x     <= '0;
            r_wr_slot  <= '0;
            r_rd_slot  <= '0;
            r_lines    <= '0;
            r_wr_ready <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_commit) begin
                r_wr_x    <= '0;
                r_wr_slot <= r_wr_slot + 1'b1;
            end else if (w_wr_mem) begin
                r_wr_x    <= r_wr_x + 1'b1;
            end
            if (w_wr_acc && w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_release) begin
                r_rd_slot <= r_rd_slot + 1'b1;
            end
            r_lines    <= w_lines_nxt;
            r_wr_ready <= (w_lines_nxt < CNT_W'(LINES));
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_mem) begin
            r_y_ram[{r_wr_slot, w_wr_addr}] <= wr_data[2*DATA_W-1:DATA_W];
            if (!w_wr_addr[0]) begin
                r_cb_ram[{r_wr_slot, w_wr_addr[ADDR_W-1:1]}] <= wr_data[DATA_W-1:0];
            end else begin
                r_cr_ram[{r_wr_slot, w_wr_addr[ADDR_W-1:1]}] <= wr_data[DATA_W-1:0];
            end
        end
    end

    // RAM read address stage inputs: direct from the request, or clamped and registered.
    logic               w_av;
    logic [ADDR_W-1:0]  w_ax0, w_ax1;
    logic [SLOT_W-1:0]  w_as0, w_as1;

`ifdef SCALER_LB_CLAMP_EN
    logic [ADDR_W-1:0]  r_last [LINES];
    logic [SLOT_W-1:0]  w_rs1;
    logic [ADDR_W-1:0]  w_cx0, w_cx1;
    logic               r_va;
    logic [ADDR_W-1:0]  r_ax0, r_ax1;
    logic [SLOT_W-1:0]  r_as0, r_as1;

    assign w_rs1 = r_rd_slot + 1'b1;
    assign w_cx0 = (rd_x > r_last[r_rd_slot]) ? r_last[r_rd_slot] : rd_x;
    assign w_cx1 = (rd_x > r_last[w_rs1]) ? r_last[w_rs1] : rd_x;

    // Stores last valid x (len-1); a dropped eol pixel leaves the line at MAX_WIDTH.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_last[r_wr_slot] <= w_wr_drop ? ADDR_W'(MAX_WIDTH-1) : w_wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sof) begin
            r_va <= 1'b0;
        end else begin
            r_va <= w_rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_ax0 <= w_cx0;
            r_ax1 <= w_cx1;
            r_as0 <= r_rd_slot;
            r_as1 <= w_rs1;
        end
    end

    assign w_av  = r_va;
    assign w_ax0 = r_ax0;
    assign w_ax1 = r_ax1;
    assign w_as0 = r_as0;
    assign w_as1 = r_as1;
`else
    assign w_av  = w_rd_acc;
    assign w_ax0 = rd_x;
    assign w_ax1 = rd_x;
    assign w_as0 = r_rd_slot;
    assign w_as1 = r_rd_slot + 1'b1;
`endif

    logic               r_v1;
    logic [DATA_W-1:0]  r_y0, r_cb0, r_cr0, r_y1, r_cb1, r_cr1;

    always_ff @(posedge clk) begin
        if (rst || sof) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_av;
        end
    end

    always_ff @(posedge clk) begin
        if (w_av) begin
            r_y0  <= r_y_ram[{w_as0, w_ax0}];
            r_cb0 <= r_cb_ram[{w_as0, w_ax0[ADDR_W-1:1]}];
            r_cr0 <= r_cr_ram[{w_as0, w_ax0[ADDR_W-1:1]}];
            r_y1  <= r_y_ram[{w_as1, w_ax1}];
            r_cb1 <= r_cb_ram[{w_as1, w_ax1[ADDR_W-1:1]}];
            r_cr1 <= r_cr_ram[{w_as1, w_ax1[ADDR_W-1:1]}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_q0    <= '0;
            rd_q1    <= '0;
        end else if (sof) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= r_v1;
            if (r_v1) begin
                rd_q0 <= {r_y0, r_cb0, r_cr0};
                rd_q1 <= {r_y1, r_cb1, r_cr1};
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign lines_avail = r_lines;
    assign wr_overflow = r_overflow;

endmodule
